// File: rtl/bn_rsqrt_scheduler.sv
// Round-robin scheduler sharing one FP16 rsqrt Newton datapath among N_REQ requesters.
// Result is valid G+1+iter_count cycles after grant G (G+1 for special x); resp_ready=0 holds DONE and blocks grants.
module bn_rsqrt_scheduler #(
  parameter int          N_REQ      = 4,
  parameter int          MAX_ITER   = 6,
  parameter int          TOL_ULP    = 1,
  parameter logic [15:0] SEED_MAGIC = 16'h59BB
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [16*N_REQ-1:0]      req_x,
  output logic [N_REQ-1:0]         gnt,
  output logic [15:0]              step_x,
  output logic [15:0]              step_y,
  input  logic [15:0]              step_y_next,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [15:0]              resp_y,
  output logic [3:0]               iter_count,
  output logic                     busy
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] resp_id_q, resp_id_d;
  logic [15:0]   x_q, x_d;
  logic [15:0]   y_q, y_d;
  logic [15:0]   resp_y_q, resp_y_d;
  logic [3:0]    k_q, k_d;
  logic [3:0]    iter_q, iter_d;
  logic [N_REQ-1:0] gnt_d;

  logic [IW-1:0] win, cand;
  logic          win_vld;
  logic [15:0]   x_in;
  logic          is_spec;
  logic [15:0]   spec_y;
  logic [9:0]    mant_diff;
  logic          conv;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(rr_ptr_q) + i) % N_REQ);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  assign x_in = req_x[{win, 4'b0000} +: 16];

  // Sign is tested first so negative NaN/inf/normals all map to NaN, while -0 falls through to +inf.
  always_comb begin
    is_spec = 1'b1;
    spec_y  = 16'h7E00;
    if (x_in[15] && x_in != 16'h8000)                      spec_y = 16'h7E00;
    else if (x_in[14:10] == 5'd0)                           spec_y = 16'h7C00;
    else if (x_in[14:10] == 5'h1F && x_in[9:0] == 10'd0)    spec_y = 16'h0000;
    else if (x_in[14:10] == 5'h1F)                          spec_y = 16'h7E00;
    else                                                    is_spec = 1'b0;
  end

  assign mant_diff = (step_y_next[9:0] >= y_q[9:0]) ? (step_y_next[9:0] - y_q[9:0])
                                                    : (y_q[9:0] - step_y_next[9:0]);
  assign conv = (step_y_next[15:10] == y_q[15:10]) && (32'(mant_diff) <= TOL_ULP);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    resp_id_d = resp_id_q;
    x_d       = x_q;
    y_d       = y_q;
    resp_y_d  = resp_y_q;
    k_d       = k_q;
    iter_d    = iter_q;
    gnt_d     = '0;
    case (state_q)
      IDLE: begin
        if (reset && win_vld) begin
          gnt_d[win] = 1'b1;
          rr_ptr_d   = win;
          resp_id_d  = win;
          x_d        = x_in;
          k_d        = 4'd0;
          if (is_spec) begin
            resp_y_d = spec_y;
            iter_d   = 4'd0;
            state_d  = DONE;
          end else begin
            y_d     = SEED_MAGIC - (x_in >> 1);
            state_d = ITER;
          end
        end
      end
      ITER: begin
        if (conv || k_q == 4'(MAX_ITER - 1)) begin
          resp_y_d = step_y_next;
          iter_d   = k_q + 4'd1;
          state_d  = DONE;
        end else begin
          y_d = step_y_next;
          k_d = k_q + 4'd1;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= IW'(N_REQ - 1);
      resp_id_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      resp_y_q  <= '0;
      k_q       <= '0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      resp_id_q <= resp_id_d;
      x_q       <= x_d;
      y_q       <= y_d;
      resp_y_q  <= resp_y_d;
      k_q       <= k_d;
      iter_q    <= iter_d;
    end
  end

  assign gnt        = gnt_d;
  assign step_x     = x_q;
  assign step_y     = y_q;
  assign resp_valid = (state_q == DONE);
  assign resp_id    = resp_id_q;
  assign resp_y     = resp_y_q;
  assign iter_count = iter_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bn_rsqrt_scheduler.sv
// Bench for bn_rsqrt_scheduler: real-valued FP16 Newton datapath (or oscillating stub),
// transaction-level reference model and per-cycle compare, plus directed literal checks.
module tb_bn_rsqrt_scheduler;
  localparam int          N_REQ      = 4;
  localparam int          MAX_ITER   = 6;
  localparam int          TOL_ULP    = 1;
  localparam logic [15:0] SEED_MAGIC = 16'h59BB;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [N_REQ-1:0]     req_r = '0;
  logic [15:0]          xv [N_REQ];
  logic [16*N_REQ-1:0]  req_x;
  logic [N_REQ-1:0]     gnt;
  logic [15:0]          step_x, step_y, step_y_next;
  logic                 resp_valid;
  logic                 resp_ready = 1'b0;
  logic [1:0]           resp_id;
  logic [15:0]          resp_y;
  logic [3:0]           iter_count;
  logic                 busy;
  logic                 stub_mode = 1'b0;

  int total = 0;
  int bad = 0;

  bn_rsqrt_scheduler #(.N_REQ(N_REQ), .MAX_ITER(MAX_ITER), .TOL_ULP(TOL_ULP), .SEED_MAGIC(SEED_MAGIC)) dut (
    .clk(clk), .reset(reset), .req(req_r), .req_x(req_x), .gnt(gnt),
    .step_x(step_x), .step_y(step_y), .step_y_next(step_y_next),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_y(resp_y), .iter_count(iter_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    m = real'(int'(h[9:0]));
    if (e == 0) m = m * (2.0 ** -24.0);
    else        m = (1.0 + m / 1024.0) * (2.0 ** real'(e - 15));
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real v);
    real  m;
    int   ex;
    int   mi;
    logic s;
    s = (v < 0.0);
    m = s ? -v : v;
    if (m == 0.0) return {s, 15'd0};
    if (m >= 65520.0) return {s, 15'h7C00};
    ex = 0;
    while (m >= 2.0) begin m = m / 2.0; ex++; end
    while (m < 1.0)  begin m = m * 2.0; ex--; end
    mi = $rtoi((m - 1.0) * 1024.0 + 0.5);
    if (mi == 1024) begin mi = 0; ex++; end
    if (ex < -14) return {s, 15'd0};
    if (ex > 15)  return {s, 15'h7C00};
    return {s, 5'(ex + 15), 10'(mi)};
  endfunction

  function automatic logic [15:0] dp(input logic [15:0] x, input logic [15:0] y, input logic stub);
    real xr, yr;
    if (stub) return (y == 16'h3800) ? 16'h3A00 : 16'h3800;
    xr = h2r(x);
    yr = h2r(y);
    return r2h(yr * (1.5 - 0.5 * xr * yr * yr));
  endfunction

  always_comb step_y_next = dp(step_x, step_y, stub_mode);

  always_comb begin
    req_x = '0;
    for (int i = 0; i < N_REQ; i++) req_x[16*i +: 16] = xv[i];
  end

  // Reference: result of one whole request, computed from the operand alone.
  function automatic void model(input logic [15:0] x, input logic stub, output logic [15:0] ry, output int it);
    logic [15:0] y, yn;
    int d;
    ry = 16'h0000;
    it = 0;
    if (x[15] && x != 16'h8000)  ry = 16'h7E00;
    else if (x[14:10] == 5'd0)   ry = 16'h7C00;
    else if (x == 16'h7C00)      ry = 16'h0000;
    else if (x[14:10] == 5'h1F)  ry = 16'h7E00;
    else begin
      y = SEED_MAGIC - (x >> 1);
      for (int k = 1; k <= MAX_ITER; k++) begin
        yn = dp(x, y, stub);
        it = k;
        ry = yn;
        d  = int'(yn[9:0]) - int'(y[9:0]);
        if (d < 0) d = -d;
        if (yn[15:10] == y[15:10] && d <= TOL_ULP) break;
        y = yn;
      end
    end
  endfunction

  function automatic int rr_pick(input logic [N_REQ-1:0] r, input int last);
    for (int i = 1; i <= N_REQ; i++)
      if (r[(last + i) % N_REQ]) return (last + i) % N_REQ;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // Compare process state
  int          cyc = 0;
  logic        outst = 1'b0;
  int          rr_last = N_REQ - 1;
  int          w_m, exp_it, exp_vcyc, gcyc_m;
  logic [15:0] exp_y, cur_x, seed_y;
  logic        seen_v;
  int          resp_count = 0;
  logic [15:0] last_y;
  int          last_id, last_it, last_vcyc, last_gcyc, last_gid;
  int          last_hcyc = -100;
  int          g_gap = 0;
  int          gq[$];
  int          iq[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_valid", 32'(resp_valid), 0);
      chk("rst_resp_y", 32'(resp_y), 0);
      chk("rst_resp_id", 32'(resp_id), 0);
      chk("rst_iter", 32'(iter_count), 0);
      chk("rst_step_x", 32'(step_x), 0);
      chk("rst_step_y", 32'(step_y), 0);
      chk("rst_busy", 32'(busy), 0);
      outst   = 1'b0;
      rr_last = N_REQ - 1;
    end else if (outst) begin
      chk("busy_gnt", 32'(gnt), 0);
      chk("busy_flag", 32'(busy), 1);
      chk("step_x", 32'(step_x), 32'(cur_x));
      if (exp_it != 0 && cyc == gcyc_m + 1) chk("seed", 32'(step_y), 32'(seed_y));
      chk("valid_time", 32'(resp_valid), 32'(cyc >= exp_vcyc));
      if (resp_valid) begin
        chk("resp_y", 32'(resp_y), 32'(exp_y));
        chk("resp_id", 32'(resp_id), 32'(w_m));
        chk("iter_count", 32'(iter_count), 32'(exp_it));
        if (!seen_v) begin seen_v = 1'b1; last_vcyc = cyc; end
        if (resp_ready) begin
          outst     = 1'b0;
          last_hcyc = cyc;
          last_y    = resp_y;
          last_id   = int'(resp_id);
          last_it   = int'(iter_count);
          iq.push_back(int'(resp_id));
          resp_count++;
        end
      end
    end else begin
      chk("idle_busy", 32'(busy), 0);
      chk("idle_valid", 32'(resp_valid), 0);
      if (req_r != '0) begin
        w_m = rr_pick(req_r, rr_last);
        chk("gnt", 32'(gnt), 32'(1) << w_m);
        rr_last = w_m;
        model(xv[w_m], stub_mode, exp_y, exp_it);
        cur_x     = xv[w_m];
        seed_y    = SEED_MAGIC - (xv[w_m] >> 1);
        gcyc_m    = cyc;
        last_gcyc = cyc;
        exp_vcyc  = cyc + 1 + exp_it;
        g_gap     = cyc - last_hcyc;
        last_gid  = w_m;
        seen_v    = 1'b0;
        outst     = 1'b1;
        gq.push_back(w_m);
      end else begin
        chk("gnt_idle", 32'(gnt), 0);
      end
    end
  end

  // Requester behaviour
  logic [N_REQ-1:0] prev_g = '0;
  logic [N_REQ-1:0] last_g = '0;
  logic [N_REQ-1:0] auto_mask = '0;
  logic             rand_x_en = 1'b0;
  logic             rand_rdy = 1'b0;

  function automatic logic [15:0] rand_x();
    if ($urandom_range(0, 7) == 0) begin
      case ($urandom_range(0, 5))
        0:       return 16'h0000;
        1:       return 16'h8000;
        2:       return 16'hC400;
        3:       return 16'h7C00;
        4:       return 16'h7E00;
        default: return 16'h0001;
      endcase
    end
    return {1'b0, 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
  endfunction

  task automatic tick();
    logic [N_REQ-1:0] g, rearm;
    @(negedge clk);
    g = gnt;
    @(posedge clk);
    #1;
    rearm = prev_g & auto_mask;
    for (int i = 0; i < N_REQ; i++)
      if (rearm[i] && rand_x_en) xv[i] = rand_x();
    req_r  = (req_r | rearm) & ~g;
    prev_g = g;
    last_g = g;
    if (rand_rdy) resp_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic wait_resp(input string nm, input int n, input int budget);
    int target;
    target = resp_count + n;
    for (int c = 0; c < budget; c++) begin
      if (resp_count >= target) break;
      tick();
    end
    if (resp_count < target) fail_now(nm);
  endtask

  task automatic wait_gnt(input string nm, input int budget);
    logic got;
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      tick();
      if (last_g != '0) got = 1'b1;
    end
    if (!got) fail_now(nm);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    logic done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      if (req_r == '0 && !busy && !resp_valid) done = 1'b1;
      else tick();
    end
    if (!done) fail_now(nm);
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    prev_g = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  function automatic int udiff(input logic [15:0] a, input logic [15:0] b);
    int d;
    d = int'(a) - int'(b);
    return (d < 0) ? -d : d;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    logic [15:0] sp_x [3];
    logic [15:0] sp_y [3];
    sp_x[0] = 16'h0000; sp_y[0] = 16'h7C00;
    sp_x[1] = 16'hC400; sp_y[1] = 16'h7E00;
    sp_x[2] = 16'h7C00; sp_y[2] = 16'h0000;
    for (int i = 0; i < N_REQ; i++) xv[i] = 16'h3C00;
    #1;
    do_reset();

    // Scenario 1: x = 4.0
    resp_ready = 1'b1;
    xv[0] = 16'h4400;
    req_r[0] = 1'b1;
    wait_gnt("s1_gnt", 10);
    chk("s1_gnt_pulse", 32'(gnt), 0);
    chk("s1_seed", 32'(step_y), 32'h37BB);
    chk("s1_step_x", 32'(step_x), 32'h4400);
    wait_resp("s1_resp", 1, 20);
    chk("s1_y_within_ulp", 32'(udiff(last_y, 16'h3800) <= 1), 1);
    chk("s1_iter_le_max", 32'(last_it >= 1 && last_it <= MAX_ITER), 1);
    chk("s1_id", 32'(last_id), 0);

    // Scenario 2: special operands
    for (int s = 0; s < 3; s++) begin
      xv[0] = sp_x[s];
      req_r[0] = 1'b1;
      wait_resp("s2_resp", 1, 20);
      chk("s2_y", 32'(last_y), 32'(sp_y[s]));
      chk("s2_iter", 32'(last_it), 0);
      chk("s2_latency", 32'(last_vcyc - last_gcyc), 1);
    end
    wait_idle("s2_idle", 20);

    // Scenario 3: all requesting continuously
    do_reset();
    gq.delete();
    iq.delete();
    for (int i = 0; i < N_REQ; i++) xv[i] = 16'h4200 + 16'(i);
    auto_mask = '1;
    req_r = '1;
    wait_resp("s3_resp", 5, 300);
    auto_mask = '0;
    wait_idle("s3_idle", 300);
    chk("s3_count", 32'(gq.size() >= 5 && iq.size() >= 5), 1);
    if (gq.size() >= 5 && iq.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("s3_gnt_order", 32'(gq[i]), 32'(i % N_REQ));
        chk("s3_id_order", 32'(iq[i]), 32'(i % N_REQ));
      end
    end

    // Scenario 4: non-converging stub
    stub_mode = 1'b1;
    xv[1] = 16'h4400;
    req_r[1] = 1'b1;
    wait_resp("s4_resp", 1, 30);
    chk("s4_iter", 32'(last_it), 6);
    chk("s4_y", 32'(last_y), 32'h3A00);
    chk("s4_latency", 32'(last_vcyc - last_gcyc), 7);
    wait_idle("s4_idle", 20);
    stub_mode = 1'b0;

    // Scenario 5: back-pressure with a pending request
    resp_ready = 1'b0;
    xv[0] = 16'h4400;
    req_r[0] = 1'b1;
    wait_gnt("s5_gnt0", 10);
    xv[2] = 16'h3C00;
    req_r[2] = 1'b1;
    for (int c = 0; c < 20 && !resp_valid; c++) tick();
    chk("s5_valid", 32'(resp_valid), 1);
    repeat (10) tick();
    chk("s5_still_valid", 32'(resp_valid), 1);
    chk("s5_gnt_blocked", 32'(gnt), 0);
    resp_ready = 1'b1;
    wait_resp("s5_resp", 2, 40);
    chk("s5_next_gid", 32'(last_gid), 2);
    chk("s5_gnt_gap", 32'(g_gap), 1);
    wait_idle("s5_idle", 20);

    // Scenario 6: reset in third ITER cycle
    stub_mode = 1'b1;
    xv[3] = 16'h4400;
    req_r[3] = 1'b1;
    wait_gnt("s6_gnt", 10);
    tick();
    tick();
    rc = resp_count;
    reset = 1'b0;
    #1;
    chk("s6_gnt", 32'(gnt), 0);
    chk("s6_valid", 32'(resp_valid), 0);
    chk("s6_step_x", 32'(step_x), 0);
    chk("s6_step_y", 32'(step_y), 0);
    chk("s6_busy", 32'(busy), 0);
    repeat (2) tick();
    reset = 1'b1;
    stub_mode = 1'b0;
    repeat (3) tick();
    chk("s6_no_resp", 32'(resp_count), 32'(rc));
    xv[1] = 16'h3C00;
    req_r[1] = 1'b1;
    wait_resp("s6_resp", 1, 20);
    chk("s6_y_within_ulp", 32'(udiff(last_y, 16'h3C00) <= 1), 1);
    chk("s6_id", 32'(last_id), 1);
    wait_idle("s6_idle", 20);

    // Randomised traffic
    rand_x_en = 1'b1;
    rand_rdy  = 1'b1;
    auto_mask = '1;
    for (int i = 0; i < N_REQ; i++) xv[i] = rand_x();
    req_r = '1;
    wait_resp("rand_resp", 40, 4000);
    auto_mask  = '0;
    rand_rdy   = 1'b0;
    resp_ready = 1'b1;
    wait_idle("rand_idle", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
